// File: rtl/wt_dcache_flush_seq_pkg.sv
// Shared write-through cache package: flush sequencer state type and drain counter sizing.
// Contents:
//   flush_seq_state_e      - flush sequencer FSM state (2 bits)
//   FLUSH_SEQ_DRAIN_MAX    - default drain timeout in cycles
//   FLUSH_SEQ_DRAIN_CNT_W  - drain counter width for the default timeout
//   flush_seq_cnt_w()      - drain counter width for an arbitrary timeout (>= 1 bit)
package wt_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WALK  = 2'd2,
    ACK   = 2'd3
  } flush_seq_state_e;

  localparam int unsigned FLUSH_SEQ_DRAIN_MAX   = 1023;
  localparam int unsigned FLUSH_SEQ_DRAIN_CNT_W = $clog2(FLUSH_SEQ_DRAIN_MAX + 1);

  // A disabled timeout (0) still needs a 1-bit counter so the vector stays legal.
  function automatic int unsigned flush_seq_cnt_w(input int unsigned drain_max);
    if (drain_max == FLUSH_SEQ_DRAIN_MAX) return FLUSH_SEQ_DRAIN_CNT_W;
    if (drain_max == 0) return 1;
    return $clog2(drain_max + 1);
  endfunction

endpackage

// File: rtl/wt_dcache_flush_seq_if.sv
// Cacheline write port between the flush sequencer and wt_dcache_mem.
// Signals:
//   wr_cl_vld   - write strobe (master -> slave)
//   wr_cl_gnt   - write accepted this cycle (slave -> master)
//   wr_cl_idx   - set index (master -> slave)
//   wr_cl_we    - per-way write enables (master -> slave)
//   wr_vld_bits - new per-way valid bits (master -> slave)
interface wt_dcache_flush_seq_if #(
  parameter int unsigned IdxWidth = 8,
  parameter int unsigned SetAssoc = 8
);

  logic                wr_cl_vld;
  logic                wr_cl_gnt;
  logic [IdxWidth-1:0] wr_cl_idx;
  logic [SetAssoc-1:0] wr_cl_we;
  logic [SetAssoc-1:0] wr_vld_bits;

  modport master (
    output wr_cl_vld,
    output wr_cl_idx,
    output wr_cl_we,
    output wr_vld_bits,
    input  wr_cl_gnt
  );

  modport slave (
    input  wr_cl_vld,
    input  wr_cl_idx,
    input  wr_cl_we,
    input  wr_vld_bits,
    output wr_cl_gnt
  );

endinterface

// File: rtl/wt_dcache_flush_walker.sv
// Set-index walker for the dcache flush.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous reset, active-high (index back to 0)
//   adv_i  - current index was granted; step to the next one
//   idx_o  - current set index
//   last_o - current index is NumSets-1
module wt_dcache_flush_walker #(
  parameter int unsigned NumSets  = 256,
  parameter int unsigned IdxWidth = $clog2(NumSets)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                adv_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                last_o
);

  logic [IdxWidth-1:0] r_idx;

  assign idx_o  = r_idx;
  assign last_o = (r_idx == IdxWidth'(NumSets - 1));

  // Explicit wrap so the index is 0 for the next flush whatever NumSets is.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx <= '0;
    end else if (adv_i) begin
      r_idx <= last_o ? '0 : r_idx + IdxWidth'(1);
    end
  end

endmodule

// File: rtl/wt_dcache_flush_seq.sv
// Write-through L1 dcache flush sequencer. Owns the cacheline write port during a flush:
// drains the write buffer / read controllers, stalls the core, then invalidates every set
// with all ways cleared. Outside a walk it forwards single-index invalidations from the
// miss unit onto the same port.
// Ports:
//   clk_i, rst_i         - clock, synchronous active-high reset
//   flush_i/flush_ack_o  - level flush request / one-cycle completion pulse
//   stall_o, busy_o      - stall new core requests / sequencer not idle
//   wbuffer_empty_i      - write buffer empty
//   ctrl_busy_i          - a read controller or the miss unit is busy
//   inv_req_i/inv_idx_i  - single-index invalidate request and index
//   inv_ack_o            - invalidate accepted this cycle
//   mem_if               - cacheline write port (wr_cl_* / wr_vld_bits)
//   drain_err_o          - sticky drain timeout, cleared on the next flush_i rise
// Optional: define WT_DCACHE_FLUSH_SEQ_PERF_EN to add flush_cycles_o / flush_cnt_o.
module wt_dcache_flush_seq
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumSets  = 256,
  parameter int unsigned SetAssoc = 8,
  parameter int unsigned IdxWidth = $clog2(NumSets),
  parameter int unsigned DrainMax = FLUSH_SEQ_DRAIN_MAX
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  flush_ack_o,
  output logic                  stall_o,
  input  logic                  wbuffer_empty_i,
  input  logic                  ctrl_busy_i,
  input  logic                  inv_req_i,
  input  logic [IdxWidth-1:0]   inv_idx_i,
  output logic                  inv_ack_o,
  wt_dcache_flush_seq_if.master mem_if,
  output logic                  busy_o,
  output logic                  drain_err_o
`ifdef WT_DCACHE_FLUSH_SEQ_PERF_EN
  ,
  output logic [31:0]           flush_cycles_o,
  output logic [15:0]           flush_cnt_o
`endif
);

  localparam int unsigned DrainCntW = flush_seq_cnt_w(DrainMax);

  flush_seq_state_e     r_state;
  flush_seq_state_e     w_state_next;
  logic                 r_flush_prev;
  logic [DrainCntW-1:0] r_drain_cnt;
  logic                 r_drain_err;

  logic                 w_flush_rise;
  logic                 w_drain_done;
  logic                 w_drain_to;
  logic                 w_walk_adv;
  logic                 w_walk_last;
  logic [IdxWidth-1:0]  w_walk_idx;

  // A flush starts only on a rising edge, so a request held past its ack cannot restart.
  assign w_flush_rise = flush_i & ~r_flush_prev;
  assign w_drain_done = wbuffer_empty_i & ~ctrl_busy_i;
  // Leaving DRAIN takes priority over flagging a timeout in the same cycle.
  assign w_drain_to   = (DrainMax != 0) && (r_state == DRAIN) && !w_drain_done &&
                        (r_drain_cnt == DrainCntW'(DrainMax));
  assign w_walk_adv   = (r_state == WALK) & mem_if.wr_cl_gnt;

  wt_dcache_flush_walker #(
    .NumSets  (NumSets),
    .IdxWidth (IdxWidth)
  ) u_walker (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .adv_i  (w_walk_adv),
    .idx_o  (w_walk_idx),
    .last_o (w_walk_last)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_flush_rise) w_state_next = DRAIN;
      DRAIN:   if (w_drain_done) w_state_next = WALK;
      WALK:    if (w_walk_adv && w_walk_last) w_state_next = ACK;
      ACK:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_flush_prev <= 1'b0;
      r_drain_cnt  <= '0;
      r_drain_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_flush_prev <= flush_i;
      // Saturates at DrainMax so the timeout condition stays asserted while stuck.
      if (r_state != DRAIN) begin
        r_drain_cnt <= '0;
      end else if (r_drain_cnt != DrainCntW'(DrainMax)) begin
        r_drain_cnt <= r_drain_cnt + DrainCntW'(1);
      end
      if (w_drain_to) begin
        r_drain_err <= 1'b1;
      end else if (w_flush_rise) begin
        r_drain_err <= 1'b0;
      end
    end
  end

  assign busy_o      = (r_state != IDLE);
  assign stall_o     = (r_state != IDLE);
  assign flush_ack_o = (r_state == ACK);
  // The timeout is visible in the cycle it is detected, then held by the sticky flag.
  assign drain_err_o = r_drain_err | w_drain_to;

  // Port arbitration: invalidations own the port outside a walk; during WALK/ACK they are
  // acknowledged for free because the walk clears every set anyway.
  always_comb begin
    mem_if.wr_cl_vld = 1'b0;
    mem_if.wr_cl_idx = '0;
    inv_ack_o        = 1'b0;
    unique case (r_state)
      IDLE, DRAIN: begin
        if (inv_req_i) begin
          mem_if.wr_cl_vld = 1'b1;
          mem_if.wr_cl_idx = inv_idx_i;
          inv_ack_o        = mem_if.wr_cl_gnt;
        end
      end
      WALK: begin
        mem_if.wr_cl_vld = 1'b1;
        mem_if.wr_cl_idx = w_walk_idx;
        inv_ack_o        = inv_req_i;
      end
      ACK: begin
        inv_ack_o = inv_req_i;
      end
      default: begin
        inv_ack_o = 1'b0;
      end
    endcase
  end

  assign mem_if.wr_cl_we    = '1;
  assign mem_if.wr_vld_bits = '0;

`ifdef WT_DCACHE_FLUSH_SEQ_PERF_EN
  logic [31:0] r_run_cycles;
  logic [31:0] r_flush_cycles;
  logic [15:0] r_flush_cnt;

  // r_run_cycles holds the DRAIN+WALK cycles so far; the ACK cycle adds one when latched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_run_cycles   <= '0;
      r_flush_cycles <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_run_cycles <= '0;
      end else if (r_run_cycles != '1) begin
        r_run_cycles <= r_run_cycles + 32'd1;
      end
      if (r_state == ACK) begin
        r_flush_cycles <= (r_run_cycles == '1) ? '1 : r_run_cycles + 32'd1;
        r_flush_cnt    <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign flush_cycles_o = r_flush_cycles;
  assign flush_cnt_o    = r_flush_cnt;
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_wt_dcache_flush_seq.sv
// Self-checking bench for wt_dcache_flush_seq (NumSets=8, SetAssoc=8, DrainMax=4).
module tb_wt_dcache_flush_seq;
  import wt_cache_pkg::*;

  localparam int unsigned NumSets  = 8;
  localparam int unsigned SetAssoc = 8;
  localparam int unsigned IdxWidth = 3;
  localparam int unsigned DrainMax = 4;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                flush_i = 1'b0;
  logic                flush_ack_o;
  logic                stall_o;
  logic                wbuffer_empty_i = 1'b1;
  logic                ctrl_busy_i = 1'b0;
  logic                inv_req_i = 1'b0;
  logic [IdxWidth-1:0] inv_idx_i = '0;
  logic                inv_ack_o;
  logic                busy_o;
  logic                drain_err_o;
`ifdef WT_DCACHE_FLUSH_SEQ_PERF_EN
  logic [31:0]         flush_cycles_o;
  logic [15:0]         flush_cnt_o;
  int                  exp_flush_cnt = 0;
`endif

  wt_dcache_flush_seq_if #(.IdxWidth(IdxWidth), .SetAssoc(SetAssoc)) mem_if ();

  wt_dcache_flush_seq #(
    .NumSets  (NumSets),
    .SetAssoc (SetAssoc),
    .IdxWidth (IdxWidth),
    .DrainMax (DrainMax)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .flush_ack_o     (flush_ack_o),
    .stall_o         (stall_o),
    .wbuffer_empty_i (wbuffer_empty_i),
    .ctrl_busy_i     (ctrl_busy_i),
    .inv_req_i       (inv_req_i),
    .inv_idx_i       (inv_idx_i),
    .inv_ack_o       (inv_ack_o),
    .mem_if          (mem_if.master),
    .busy_o          (busy_o),
    .drain_err_o     (drain_err_o)
`ifdef WT_DCACHE_FLUSH_SEQ_PERF_EN
    ,
    .flush_cycles_o  (flush_cycles_o),
    .flush_cnt_o     (flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  bit exp_err  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_inv(input bit en);
    inv_req_i = en ? 1'($urandom % 2) : 1'b0;
    inv_idx_i = IdxWidth'($urandom % NumSets);
  endtask

  // Expected port use while invalidations own the port (IDLE or DRAIN).
  task automatic chk_arb_owned(input string tag);
    chk({tag, "_vld"}, mem_if.wr_cl_vld, inv_req_i);
    chk({tag, "_idx"}, mem_if.wr_cl_idx, inv_req_i ? inv_idx_i : 0);
    chk({tag, "_inv_ack"}, inv_ack_o, inv_req_i & mem_if.wr_cl_gnt);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_stall"}, stall_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ack"}, flush_ack_o, 0);
    chk({tag, "_vld"}, mem_if.wr_cl_vld, 0);
    chk({tag, "_idx"}, mem_if.wr_cl_idx, 0);
    chk({tag, "_we"}, mem_if.wr_cl_we, 32'hFF);
    chk({tag, "_vbits"}, mem_if.wr_vld_bits, 0);
    chk({tag, "_err"}, drain_err_o, 0);
    chk({tag, "_inv_ack"}, inv_ack_o, 0);
  endtask

  // One full flush from IDLE. drain_wait: DRAIN cycles that are not yet drained.
  // gnt_mode: 0 always granted, 1 granted every other cycle (low first), 2 random.
  task automatic run_flush(input int drain_wait, input int gnt_mode, input bit rand_inv,
                           input bit hold_flush, output int walk_cyc);
    int e;
    bit g;
    int drop_at;
    drop_at = hold_flush ? 1000 : int'($urandom % NumSets);
    // IDLE cycle that sees the rise; an invalidate may be served in the same cycle.
    flush_i = 1'b1;
    wbuffer_empty_i = (drain_wait == 0);
    ctrl_busy_i = 1'b0;
    drive_inv(rand_inv);
    mem_if.wr_cl_gnt = 1'($urandom % 2);
    @(negedge clk_i);
    chk("start_busy", busy_o, 0);
    chk("start_stall", stall_o, 0);
    chk("start_err", drain_err_o, exp_err);
    chk_arb_owned("start");
    exp_err = 1'b0;
    tick();
    for (int k = 0; k <= drain_wait; k++) begin
      if (k < drain_wait) begin
        case ($urandom % 3)
          0: begin wbuffer_empty_i = 1'b0; ctrl_busy_i = 1'b0; end
          1: begin wbuffer_empty_i = 1'b0; ctrl_busy_i = 1'b1; end
          default: begin wbuffer_empty_i = 1'b1; ctrl_busy_i = 1'b1; end
        endcase
      end else begin
        wbuffer_empty_i = 1'b1;
        ctrl_busy_i = 1'b0;
      end
      drive_inv(rand_inv);
      mem_if.wr_cl_gnt = 1'($urandom % 2);
      @(negedge clk_i);
      // Timeout shows on the (DrainMax+1)-th undrained DRAIN cycle and is sticky.
      if (k >= int'(DrainMax) && k < drain_wait) exp_err = 1'b1;
      chk("drain_stall", stall_o, 1);
      chk("drain_ack", flush_ack_o, 0);
      chk("drain_err", drain_err_o, exp_err);
      chk_arb_owned("drain");
      tick();
    end
    e = 0;
    walk_cyc = 0;
    ctrl_busy_i = 1'($urandom % 2);
    while (e < int'(NumSets) && walk_cyc < 100) begin
      case (gnt_mode)
        0: g = 1'b1;
        1: g = (walk_cyc % 2) == 1;
        default: g = 1'($urandom % 2);
      endcase
      mem_if.wr_cl_gnt = g;
      drive_inv(rand_inv);
      if (walk_cyc == drop_at) flush_i = 1'b0;
      @(negedge clk_i);
      chk("walk_vld", mem_if.wr_cl_vld, 1);
      chk("walk_idx", mem_if.wr_cl_idx, e);
      chk("walk_ack", flush_ack_o, 0);
      chk("walk_stall", stall_o, 1);
      chk("walk_inv_ack", inv_ack_o, inv_req_i);
      chk("walk_err", drain_err_o, exp_err);
      if (g) e++;
      walk_cyc++;
      tick();
    end
    if (e < int'(NumSets)) chk("walk_bound", e, NumSets);
    drive_inv(rand_inv);
    mem_if.wr_cl_gnt = 1'($urandom % 2);
    @(negedge clk_i);
    chk("ack_pulse", flush_ack_o, 1);
    chk("ack_vld", mem_if.wr_cl_vld, 0);
    chk("ack_stall", stall_o, 1);
    chk("ack_inv_ack", inv_ack_o, inv_req_i);
    tick();
    inv_req_i = 1'b0;
    @(negedge clk_i);
    chk("post_ack", flush_ack_o, 0);
    chk("post_stall", stall_o, 0);
    chk("post_busy", busy_o, 0);
    chk("post_err", drain_err_o, exp_err);
`ifdef WT_DCACHE_FLUSH_SEQ_PERF_EN
    exp_flush_cnt++;
    chk("perf_cycles", flush_cycles_o, drain_wait + 1 + walk_cyc + 1);
    chk("perf_cnt", flush_cnt_o, exp_flush_cnt);
`endif
  endtask

  typedef struct {
    bit                  req;
    logic [IdxWidth-1:0] idx;
    bit                  gnt;
    bit                  exp_vld;
    logic [IdxWidth-1:0] exp_idx;
    bit                  exp_ack;
  } inv_vec_t;

  inv_vec_t vecs[6];
  int       wc;

  initial begin
    vecs[0] = '{req: 1'b1, idx: 3'd3, gnt: 1'b1, exp_vld: 1'b1, exp_idx: 3'd3, exp_ack: 1'b1};
    vecs[1] = '{req: 1'b1, idx: 3'd5, gnt: 1'b0, exp_vld: 1'b1, exp_idx: 3'd5, exp_ack: 1'b0};
    vecs[2] = '{req: 1'b0, idx: 3'd6, gnt: 1'b1, exp_vld: 1'b0, exp_idx: 3'd0, exp_ack: 1'b0};
    vecs[3] = '{req: 1'b1, idx: 3'd7, gnt: 1'b1, exp_vld: 1'b1, exp_idx: 3'd7, exp_ack: 1'b1};
    vecs[4] = '{req: 1'b0, idx: 3'd2, gnt: 1'b0, exp_vld: 1'b0, exp_idx: 3'd0, exp_ack: 1'b0};
    vecs[5] = '{req: 1'b1, idx: 3'd0, gnt: 1'b1, exp_vld: 1'b1, exp_idx: 3'd0, exp_ack: 1'b1};

    mem_if.wr_cl_gnt = 1'b0;
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset_outs("reset");
    tick();

    // Invalidate arbitration in IDLE.
    foreach (vecs[i]) begin
      inv_req_i = vecs[i].req;
      inv_idx_i = vecs[i].idx;
      mem_if.wr_cl_gnt = vecs[i].gnt;
      @(negedge clk_i);
      chk($sformatf("idle_inv%0d_vld", i), mem_if.wr_cl_vld, vecs[i].exp_vld);
      chk($sformatf("idle_inv%0d_idx", i), mem_if.wr_cl_idx, vecs[i].exp_idx);
      chk($sformatf("idle_inv%0d_ack", i), inv_ack_o, vecs[i].exp_ack);
      chk($sformatf("idle_inv%0d_busy", i), busy_o, 0);
      tick();
    end
    inv_req_i = 1'b0;

    // Straight flush: 8 walk cycles, request held after ack.
    run_flush(0, 0, 1'b0, 1'b1, wc);
    chk("walk_len_gnt1", wc, NumSets);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk_i);
      chk("held_no_restart", busy_o, 0);
    end
    flush_i = 1'b0;
    tick();

    // Slow drain: 5 undrained cycles (this also trips the DrainMax=4 timeout).
    run_flush(5, 0, 1'b0, 1'b1, wc);
    chk("walk_len_drain5", wc, NumSets);
    chk("err_sticky_idle", drain_err_o, 1);
    flush_i = 1'b0;
    tick();

    // Alternating grant: every index held until granted, 16 walk cycles.
    run_flush(0, 1, 1'b1, 1'b0, wc);
    chk("walk_len_alt", wc, 2 * NumSets);
    flush_i = 1'b0;
    tick();

    // Long drain stall: err rises on the 5th DRAIN cycle and stays, cleared by the next rise.
    run_flush(9, 2, 1'b1, 1'b1, wc);
    flush_i = 1'b0;
    tick();

    // Reset while the walk sits at index 4.
    flush_i = 1'b1;
    wbuffer_empty_i = 1'b1;
    ctrl_busy_i = 1'b0;
    mem_if.wr_cl_gnt = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (5) tick();
    @(negedge clk_i);
    chk("mid_walk_idx", mem_if.wr_cl_idx, 4);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset_outs("mid_rst");
    exp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk_i);
      chk("mid_rst_no_ack", flush_ack_o, 0);
    end
`ifdef WT_DCACHE_FLUSH_SEQ_PERF_EN
    exp_flush_cnt = 0;
`endif
    tick();
    run_flush(0, 0, 1'b0, 1'b0, wc);
    chk("walk_len_after_rst", wc, NumSets);
    flush_i = 1'b0;
    tick();

    // Randomised flushes against the sequence model.
    for (int n = 0; n < 8; n++) begin
      run_flush(int'($urandom % 7), 2, 1'b1, 1'($urandom % 2), wc);
      flush_i = 1'b0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
